// File: rtl/stream_conv_pkg.sv
// Shared types and elaboration helpers for the stream width converter.
// Covers mode selection, width ratio, config legality and slot placement within the wide word.
package stream_conv_pkg;

    typedef enum logic [1:0] {
        MODE_PACK   = 2'd0,
        MODE_UNPACK = 2'd1,
        MODE_PASS   = 2'd2
    } conv_mode_e;

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_BUSY  = 1'b1
    } unpack_state_e;

    function automatic int conv_ratio(input int in_w, input int out_w);
        int ratio;
        if (in_w >= out_w) begin
            ratio = in_w / out_w;
        end else begin
            ratio = out_w / in_w;
        end
        return ratio;
    endfunction

    function automatic conv_mode_e conv_mode(input int in_w, input int out_w);
        conv_mode_e mode;
        if (in_w < out_w) begin
            mode = MODE_PACK;
        end else if (in_w > out_w) begin
            mode = MODE_UNPACK;
        end else begin
            mode = MODE_PASS;
        end
        return mode;
    endfunction

    function automatic bit conv_legal(input int in_w, input int out_w);
        bit legal;
        if ((in_w < 1) || (out_w < 1)) begin
            legal = 1'b0;
        end else if (in_w >= out_w) begin
            legal = ((in_w % out_w) == 0);
        end else begin
            legal = ((out_w % in_w) == 0);
        end
        return legal;
    endfunction

    // Bit offset of slot idx; slot 0 is the first chunk in time.
    function automatic int slot_lsb(input int idx, input int ratio, input int w, input int msb_first);
        int lsb;
        if (msb_first != 0) begin
            lsb = (ratio - 1 - idx) * w;
        end else begin
            lsb = idx * w;
        end
        return lsb;
    endfunction

endpackage

// File: rtl/stream_width_converter.sv
// Ready/valid width converter: packs narrow chunks into wide words, unpacks wide words, or passes through.
// Optional macro STREAM_WIDTH_CONVERTER_FLUSH_EN adds a flush input that emits a zero-padded partial word (pack mode).
module stream_width_converter
    import stream_conv_pkg::*;
#(
    parameter int IN_W      = 1,
    parameter int OUT_W     = 8,
    parameter int MSB_FIRST = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [IN_W-1:0]  data_in,
    input  logic             data_in_valid,
    output logic             data_in_ready,
    output logic [OUT_W-1:0] data_out,
    output logic             data_out_valid,
    input  logic             data_out_ready
`ifdef STREAM_WIDTH_CONVERTER_FLUSH_EN
    ,
    input  logic             flush
`endif
);

    localparam int               RATIO    = conv_ratio(IN_W, OUT_W);
    localparam conv_mode_e       MODE     = conv_mode(IN_W, OUT_W);
    localparam int               CW       = $clog2(RATIO);
    localparam int               CNT_W    = (CW < 1) ? 1 : CW;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(RATIO - 1);
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    if (!conv_legal(IN_W, OUT_W)) begin : g_bad_cfg
        $error("stream_width_converter: widths must be equal or integer multiples");
    end

    logic [CNT_W-1:0] cnt_r;
    logic [OUT_W-1:0] data_out_r;
    logic             data_out_valid_r;
    logic             in_ready_s;
    logic             in_fire_s;
    logic             out_fire_s;
    logic             out_free_s;
    logic             flush_s;
    logic             unused_s;

`ifdef STREAM_WIDTH_CONVERTER_FLUSH_EN
    assign flush_s = (MODE == MODE_PACK) ? flush : 1'b0;
`else
    assign flush_s = 1'b0;
`endif

    assign in_fire_s      = data_in_valid && in_ready_s;
    assign out_fire_s     = data_out_valid_r && data_out_ready;
    assign out_free_s     = !data_out_valid_r || data_out_ready;
    assign data_in_ready  = in_ready_s;
    assign data_out       = data_out_r;
    assign data_out_valid = data_out_valid_r;
    assign unused_s       = ^{flush_s, out_free_s, cnt_r, LAST_CNT};

    if (MODE == MODE_PACK) begin : g_pack
        logic [OUT_W-1:0] acc_r;
        logic [OUT_W-1:0] word_s;
        logic             complete_s;
        logic             flush_emit_s;

        // Overlay the accepted chunk onto its slot of the accumulated word.
        always_comb begin
            word_s = acc_r;
            for (int i = 0; i < RATIO; i++) begin
                word_s[slot_lsb(i, RATIO, IN_W, MSB_FIRST) +: IN_W] =
                    (in_fire_s && (cnt_r == CNT_W'(i))) ? data_in
                                                         : acc_r[slot_lsb(i, RATIO, IN_W, MSB_FIRST) +: IN_W];
            end
        end

        // Only the completing chunk waits for the output register; earlier slots keep filling.
        assign in_ready_s   = out_free_s || (cnt_r != LAST_CNT);
        assign complete_s   = in_fire_s && (cnt_r == LAST_CNT);
        assign flush_emit_s = flush_s && out_free_s && ((cnt_r != CNT_ZERO) || in_fire_s);

        // Accumulate chunks and move completed or flushed words into the output register.
        always_ff @(posedge clk) begin
            if (rst) begin
                acc_r            <= {OUT_W{1'b0}};
                cnt_r            <= CNT_ZERO;
                data_out_r       <= {OUT_W{1'b0}};
                data_out_valid_r <= 1'b0;
            end else if (complete_s || flush_emit_s) begin
                acc_r            <= {OUT_W{1'b0}};
                cnt_r            <= CNT_ZERO;
                data_out_r       <= word_s;
                data_out_valid_r <= 1'b1;
            end else begin
                if (out_fire_s) begin
                    data_out_valid_r <= 1'b0;
                end
                if (in_fire_s) begin
                    acc_r <= word_s;
                    cnt_r <= cnt_r + CNT_ONE;
                end
            end
        end
    end else if (MODE == MODE_UNPACK) begin : g_unpack
        unpack_state_e    state_r;
        unpack_state_e    state_next_s;
        logic [IN_W-1:0]  shift_r;
        logic [OUT_W-1:0] first_slice_s;
        logic [OUT_W-1:0] next_slice_s;

        assign in_ready_s = (state_r == ST_EMPTY) || (data_out_ready && (cnt_r == LAST_CNT));

        // Pick the first slice of an incoming word and the slice after cnt of the held word.
        always_comb begin
            first_slice_s = data_in[slot_lsb(0, RATIO, OUT_W, MSB_FIRST) +: OUT_W];
            next_slice_s  = {OUT_W{1'b0}};
            for (int i = 1; i < RATIO; i++) begin
                next_slice_s = (cnt_r == CNT_W'(i - 1)) ? shift_r[slot_lsb(i, RATIO, OUT_W, MSB_FIRST) +: OUT_W]
                                                          : next_slice_s;
            end
        end

        // EMPTY/BUSY next-state decision.
        always_comb begin
            state_next_s = state_r;
            case (state_r)
                ST_EMPTY: begin
                    if (in_fire_s) begin
                        state_next_s = ST_BUSY;
                    end else begin
                        state_next_s = ST_EMPTY;
                    end
                end
                ST_BUSY: begin
                    if (out_fire_s && (cnt_r == LAST_CNT) && !in_fire_s) begin
                        state_next_s = ST_EMPTY;
                    end else begin
                        state_next_s = ST_BUSY;
                    end
                end
                default: state_next_s = ST_EMPTY;
            endcase
        end

        // State register.
        always_ff @(posedge clk) begin
            if (rst) begin
                state_r <= ST_EMPTY;
            end else begin
                state_r <= state_next_s;
            end
        end

        // Load a fresh word, or step to the next slice on each output transfer.
        always_ff @(posedge clk) begin
            if (rst) begin
                shift_r          <= {IN_W{1'b0}};
                cnt_r            <= CNT_ZERO;
                data_out_r       <= {OUT_W{1'b0}};
                data_out_valid_r <= 1'b0;
            end else if (in_fire_s) begin
                shift_r          <= data_in;
                cnt_r            <= CNT_ZERO;
                data_out_r       <= first_slice_s;
                data_out_valid_r <= 1'b1;
            end else if (out_fire_s) begin
                if (cnt_r == LAST_CNT) begin
                    cnt_r            <= CNT_ZERO;
                    data_out_valid_r <= 1'b0;
                end else begin
                    cnt_r      <= cnt_r + CNT_ONE;
                    data_out_r <= next_slice_s;
                end
            end
        end
    end else begin : g_pass
        assign in_ready_s = out_free_s;

        // Single-entry register slice.
        always_ff @(posedge clk) begin
            if (rst) begin
                cnt_r            <= CNT_ZERO;
                data_out_r       <= {OUT_W{1'b0}};
                data_out_valid_r <= 1'b0;
            end else begin
                cnt_r <= CNT_ZERO;
                if (in_fire_s) begin
                    data_out_r       <= OUT_W'(data_in);
                    data_out_valid_r <= 1'b1;
                end else if (out_fire_s) begin
                    data_out_valid_r <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_stream_width_converter.sv
// Scoreboard bench for stream_width_converter across pack, unpack and pass-through configurations.
// The flush scenario is exercised when STREAM_WIDTH_CONVERTER_FLUSH_EN is defined.
module tb_stream_width_converter;

    int checks   = 0;
    int failures = 0;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // a: 1->8 MSB first
    logic       a_din = 1'b0, a_iv = 1'b0, a_or = 1'b0, a_flush = 1'b0;
    logic       a_ir, a_ov;
    logic [7:0] a_dout;
    // b: 8->1 LSB first
    logic [7:0] b_din = 8'h00;
    logic       b_iv = 1'b0, b_or = 1'b0;
    logic       b_ir, b_ov, b_dout;
    // c: 2->8 MSB first
    logic [1:0] c_din = 2'd0;
    logic       c_iv = 1'b0, c_or = 1'b0;
    logic       c_ir, c_ov;
    logic [7:0] c_dout;
    // d: 32->8 MSB first
    logic [31:0] d_din = 32'h0;
    logic        d_iv = 1'b0, d_or = 1'b0;
    logic        d_ir, d_ov;
    logic [7:0]  d_dout;
    // e: 4->4 pass-through
    logic [3:0] e_din = 4'h0;
    logic       e_iv = 1'b0, e_or = 1'b0;
    logic       e_ir, e_ov;
    logic [3:0] e_dout;

    stream_width_converter #(.IN_W(1), .OUT_W(8), .MSB_FIRST(1)) u_a (
        .clk(clk), .rst(rst), .data_in(a_din), .data_in_valid(a_iv), .data_in_ready(a_ir),
        .data_out(a_dout), .data_out_valid(a_ov), .data_out_ready(a_or)
`ifdef STREAM_WIDTH_CONVERTER_FLUSH_EN
        , .flush(a_flush)
`endif
    );
    stream_width_converter #(.IN_W(8), .OUT_W(1), .MSB_FIRST(0)) u_b (
        .clk(clk), .rst(rst), .data_in(b_din), .data_in_valid(b_iv), .data_in_ready(b_ir),
        .data_out(b_dout), .data_out_valid(b_ov), .data_out_ready(b_or)
`ifdef STREAM_WIDTH_CONVERTER_FLUSH_EN
        , .flush(1'b0)
`endif
    );
    stream_width_converter #(.IN_W(2), .OUT_W(8), .MSB_FIRST(1)) u_c (
        .clk(clk), .rst(rst), .data_in(c_din), .data_in_valid(c_iv), .data_in_ready(c_ir),
        .data_out(c_dout), .data_out_valid(c_ov), .data_out_ready(c_or)
`ifdef STREAM_WIDTH_CONVERTER_FLUSH_EN
        , .flush(1'b0)
`endif
    );
    stream_width_converter #(.IN_W(32), .OUT_W(8), .MSB_FIRST(1)) u_d (
        .clk(clk), .rst(rst), .data_in(d_din), .data_in_valid(d_iv), .data_in_ready(d_ir),
        .data_out(d_dout), .data_out_valid(d_ov), .data_out_ready(d_or)
`ifdef STREAM_WIDTH_CONVERTER_FLUSH_EN
        , .flush(1'b0)
`endif
    );
    stream_width_converter #(.IN_W(4), .OUT_W(4), .MSB_FIRST(1)) u_e (
        .clk(clk), .rst(rst), .data_in(e_din), .data_in_valid(e_iv), .data_in_ready(e_ir),
        .data_out(e_dout), .data_out_valid(e_ov), .data_out_ready(e_or)
`ifdef STREAM_WIDTH_CONVERTER_FLUSH_EN
        , .flush(1'b0)
`endif
    );

    logic       a_part[$];
    logic [1:0] c_part[$];
    logic [7:0] a_q[$];
    logic       b_q[$];
    logic [7:0] c_q[$];
    logic [7:0] d_q[$];
    logic [3:0] e_q[$];
    int b_run = 0;
    int b_maxrun = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic unexpected(input string name, input logic [31:0] act);
        checks++;
        failures++;
        $display("FAIL %s actual=%0h required=no_output", name, act);
    endtask

    // Wide word from the first-in-time chunks: first chunk lands in the top slice, empty slots are zero.
    function automatic logic [7:0] pack_a();
        logic [7:0] w = 8'h00;
        for (int k = 0; k < a_part.size(); k++) w = w | (8'(a_part[k]) << (7 - k));
        return w;
    endfunction

    function automatic logic [7:0] pack_c();
        logic [7:0] w = 8'h00;
        for (int k = 0; k < c_part.size(); k++) w = w | (8'(c_part[k]) << (2 * (3 - k)));
        return w;
    endfunction

    // Reference model: turn each observed input transfer into predicted output items.
    always @(negedge clk) begin
        if (rst) begin
            a_part.delete(); c_part.delete();
            a_q.delete(); b_q.delete(); c_q.delete(); d_q.delete(); e_q.delete();
        end else begin
            if (a_iv && a_ir) a_part.push_back(a_din);
            if ((a_part.size() == 8) || (a_flush && (a_part.size() > 0))) begin
                a_q.push_back(pack_a());
                a_part.delete();
            end
            if (b_iv && b_ir) for (int k = 0; k < 8; k++) b_q.push_back(b_din[k]);
            if (c_iv && c_ir) c_part.push_back(c_din);
            if (c_part.size() == 4) begin
                c_q.push_back(pack_c());
                c_part.delete();
            end
            if (d_iv && d_ir) for (int k = 0; k < 4; k++) d_q.push_back(8'(d_din >> (8 * (3 - k))));
            if (e_iv && e_ir) e_q.push_back(e_din);
        end
    end

    // Scoreboard: each output transfer must match the oldest outstanding prediction.
    always @(negedge clk) begin
        if (!rst) begin
            if (a_ov && a_or) begin
                if (a_q.size() == 0) unexpected("a_extra", 32'(a_dout));
                else check("a_data", 32'(a_dout), 32'(a_q.pop_front()));
            end
            if (b_ov && b_or) begin
                if (b_q.size() == 0) unexpected("b_extra", 32'(b_dout));
                else check("b_data", 32'(b_dout), 32'(b_q.pop_front()));
            end
            if (c_ov && c_or) begin
                if (c_q.size() == 0) unexpected("c_extra", 32'(c_dout));
                else check("c_data", 32'(c_dout), 32'(c_q.pop_front()));
            end
            if (d_ov && d_or) begin
                if (d_q.size() == 0) unexpected("d_extra", 32'(d_dout));
                else check("d_data", 32'(d_dout), 32'(d_q.pop_front()));
            end
            if (e_ov && e_or) begin
                if (e_q.size() == 0) unexpected("e_extra", 32'(e_dout));
                else check("e_data", 32'(e_dout), 32'(e_q.pop_front()));
            end
        end
    end

    // Longest run of consecutive valid cycles on the 8->1 output.
    always @(negedge clk) begin
        if (b_ov) b_run = b_run + 1;
        else b_run = 0;
        if (b_run > b_maxrun) b_maxrun = b_run;
    end

    function automatic bit in_fire(input int d);
        case (d)
            0: return a_iv && a_ir;
            1: return b_iv && b_ir;
            2: return c_iv && c_ir;
            3: return d_iv && d_ir;
            default: return 1'b0;
        endcase
    endfunction

    task automatic wait_in(input int d, input string name);
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (in_fire(d)) return;
        end
        checks++;
        failures++;
        $display("FAIL %s_timeout actual=no_accept required=accept", name);
    endtask

    task automatic send_a_byte(input logic [7:0] v, input string name);
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            a_iv = 1'b1;
            a_din = v[7 - i];
            wait_in(0, name);
        end
        @(posedge clk); #1;
        a_iv = 1'b0;
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        int n;
        int cnt;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_a_ov", 32'(a_ov), 32'd0);
        check("rst_a_dout", 32'(a_dout), 32'd0);
        check("rst_a_ir", 32'(a_ir), 32'd1);
        check("rst_b_ir", 32'(b_ir), 32'd1);
        check("rst_d_ov", 32'(d_ov), 32'd0);

        // 1->8: A5 appears one cycle after the last bit, valid for exactly one cycle
        a_or = 1'b1;
        send_a_byte(8'hA5, "t1");
        @(negedge clk);
        check("t1_valid", 32'(a_ov), 32'd1);
        check("t1_data", 32'(a_dout), 32'hA5);
        @(posedge clk); #1;
        @(negedge clk);
        check("t1_one_cycle", 32'(a_ov), 32'd0);

        // 8->1 LSB first, second word accepted during the last bit
        b_or = 1'b1;
        b_maxrun = 0;
        @(posedge clk); #1;
        b_iv = 1'b1;
        b_din = 8'hA5;
        wait_in(1, "t2a");
        @(posedge clk); #1;
        b_din = 8'h3C;
        wait_in(1, "t2b");
        @(posedge clk); #1;
        b_iv = 1'b0;
        repeat (18) @(negedge clk);
        check("t2_no_gap", 32'(b_maxrun), 32'd16);
        check("t2_drained", 32'(b_q.size()), 32'd0);

        // 2->8 with downstream stalled
        c_or = 1'b0;
        k = 0;
        for (int cyc = 0; cyc < 10; cyc++) begin
            @(posedge clk); #1;
            c_iv = 1'b1;
            c_din = 2'(k % 4);
            @(negedge clk);
            if (c_ir) k++;
            if (c_ov) check("t3_hold", 32'(c_dout), 32'h1B);
        end
        check("t3_accepted", 32'(k), 32'd7);
        check("t3_ready_low", 32'(c_ir), 32'd0);
        check("t3_valid_held", 32'(c_ov), 32'd1);
        @(posedge clk); #1;
        c_or = 1'b1;
        c_din = 2'(k % 4);
        wait_in(2, "t3c");
        @(posedge clk); #1;
        c_iv = 1'b0;
        repeat (4) @(negedge clk);
        check("t3_drained", 32'(c_q.size()), 32'd0);

        // 32->8, reset after two bytes, then a fresh word
        d_or = 1'b1;
        @(posedge clk); #1;
        d_iv = 1'b1;
        d_din = 32'h12345678;
        wait_in(3, "t4a");
        @(posedge clk); #1;
        d_iv = 1'b0;
        n = 0;
        for (int i = 0; i < 20 && n < 2; i++) begin
            @(negedge clk);
            if (d_ov && d_or) n++;
        end
        check("t4_emitted", 32'(n), 32'd2);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("t4_rst_valid", 32'(d_ov), 32'd0);
        check("t4_rst_data", 32'(d_dout), 32'd0);
        cnt = 0;
        repeat (4) begin
            @(negedge clk);
            if (d_ov) cnt++;
        end
        check("t4_no_more", 32'(cnt), 32'd0);
        @(posedge clk); #1;
        d_iv = 1'b1;
        d_din = 32'hDEADBEEF;
        wait_in(3, "t4b");
        @(posedge clk); #1;
        d_iv = 1'b0;
        repeat (6) @(negedge clk);
        check("t4_drained", 32'(d_q.size()), 32'd0);

`ifdef STREAM_WIDTH_CONVERTER_FLUSH_EN
        // Flush a three-bit partial word, then a full byte proves the slot counter restarted
        a_or = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            a_iv = 1'b1;
            a_din = 1'b1;
            wait_in(0, "t5");
        end
        @(posedge clk); #1;
        a_iv = 1'b0;
        a_flush = 1'b1;
        @(negedge clk);
        @(posedge clk); #1;
        a_flush = 1'b0;
        @(negedge clk);
        check("t5_valid", 32'(a_ov), 32'd1);
        check("t5_data", 32'(a_dout), 32'hE0);
        send_a_byte(8'h5A, "t5b");
        repeat (3) @(negedge clk);
        check("t5_drained", 32'(a_q.size()), 32'd0);
`endif

        // Random valid/ready traffic on every configuration
        for (int cyc = 0; cyc < 1000; cyc++) begin
            @(posedge clk); #1;
            a_iv = 1'($urandom); a_din = 1'($urandom); a_or = 1'($urandom);
            b_iv = 1'($urandom); b_din = 8'($urandom); b_or = 1'($urandom);
            c_iv = 1'($urandom); c_din = 2'($urandom); c_or = 1'($urandom);
            d_iv = 1'($urandom_range(0, 3) == 0); d_din = $urandom; d_or = 1'($urandom);
            e_iv = 1'($urandom); e_din = 4'($urandom); e_or = 1'($urandom);
        end
        @(posedge clk); #1;
        a_iv = 1'b0; b_iv = 1'b0; c_iv = 1'b0; d_iv = 1'b0; e_iv = 1'b0;
        a_or = 1'b1; b_or = 1'b1; c_or = 1'b1; d_or = 1'b1; e_or = 1'b1;
        repeat (40) @(negedge clk);
        check("rand_a_drained", 32'(a_q.size()), 32'd0);
        check("rand_b_drained", 32'(b_q.size()), 32'd0);
        check("rand_c_drained", 32'(c_q.size()), 32'd0);
        check("rand_d_drained", 32'(d_q.size()), 32'd0);
        check("rand_e_drained", 32'(e_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
